// File: rtl/working_time_counter.sv
// working_time_counter: accumulates fan run time as hour/min/sec for the cleaning reminder.
// Pauses outside COUNT, zeroes on self-clean completion or a standby manual clear.
module working_time_counter #(
    parameter int TICKS_PER_SEC = 100,
    parameter int HOUR_MAX      = 63
) (
    input  logic       clk_100Hz,
    input  logic       rst_n,
    input  logic       is_standby,
    input  logic       is_working,
    input  logic       self_clean_active,
    input  logic       self_clean_done,
    input  logic       clear_press_once,
    output logic [5:0] working_hour,
    output logic [5:0] working_min,
    output logic [5:0] working_sec,
    output logic [1:0] count_state,
    output logic       sec_tick,
    output logic       saturated
);
    typedef enum logic [1:0] {STOP = 2'b00, COUNT = 2'b01, CLEAN = 2'b10} state_e;

    localparam logic [6:0] PRE_LAST = 7'(TICKS_PER_SEC - 1);
    localparam logic [5:0] HR_LAST  = 6'(HOUR_MAX);

    state_e     state_q;
    logic [6:0] pre_q;
    logic [5:0] hr_q, mn_q, sc_q, hr_d, mn_d, sc_d;
    logic       tick_q, sat_q;
    logic       wrap, sc_last, mn_last, clear;

    assign wrap    = state_q == COUNT && !sat_q && pre_q == PRE_LAST;
    assign sc_last = sc_q == 6'd59;
    assign mn_last = mn_q == 6'd59;
    assign sc_d    = sc_last ? 6'd0 : sc_q + 6'd1;
    assign mn_d    = sc_last ? (mn_last ? 6'd0 : mn_q + 6'd1) : mn_q;
    assign hr_d    = sc_last && mn_last ? hr_q + 6'd1 : hr_q;
    // Both clear sources live in states where no second can be counted.
    assign clear   = (state_q == STOP && is_standby && clear_press_once) ||
                     (state_q == CLEAN && !self_clean_active && self_clean_done);

    always_ff @(posedge clk_100Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STOP;
            pre_q   <= '0;
            hr_q    <= '0;
            mn_q    <= '0;
            sc_q    <= '0;
            tick_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (state_q == COUNT && !sat_q) begin
                pre_q <= wrap ? 7'd0 : pre_q + 7'd1;
                if (wrap) begin
                    tick_q <= 1'b1;
                    sc_q   <= sc_d;
                    mn_q   <= mn_d;
                    hr_q   <= hr_d;
                    sat_q  <= hr_q == HR_LAST && mn_last && sc_q == 6'd58;
                end
            end
            if (clear) begin
                pre_q  <= '0;
                hr_q   <= '0;
                mn_q   <= '0;
                sc_q   <= '0;
                tick_q <= 1'b0;
                sat_q  <= 1'b0;
            end
            if (self_clean_active)
                state_q <= CLEAN;
            else
                case (state_q)
                    STOP:    state_q <= is_working ? COUNT : STOP;
                    COUNT:   state_q <= is_working ? COUNT : STOP;
                    default: state_q <= STOP;
                endcase
        end
    end

    assign working_hour = hr_q;
    assign working_min  = mn_q;
    assign working_sec  = sc_q;
    assign count_state  = state_q;
    assign sec_tick     = tick_q;
    assign saturated    = sat_q;
endmodule

// File: tb/tb_working_time_counter.sv
// tb_working_time_counter: directed bench with a scoreboard of expected snapshots.
// Uses a short second and a small hour ceiling so the whole range is reachable quickly.
module tb_working_time_counter;
    localparam int T = 4;
    localparam int H = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       is_standby = 1'b0, is_working = 1'b0;
    logic       self_clean_active = 1'b0, self_clean_done = 1'b0, clear_press_once = 1'b0;
    logic [5:0] working_hour, working_min, working_sec;
    logic [1:0] count_state;
    logic       sec_tick, saturated;
    logic [21:0] obs;

    int n_assert = 0;
    int n_fail = 0;
    int ticks = 0;
    int t0;

    typedef struct {
        string       tag;
        logic [21:0] val;
    } exp_t;
    exp_t sb[$];

    working_time_counter #(.TICKS_PER_SEC(T), .HOUR_MAX(H)) dut (
        .clk_100Hz(clk),
        .rst_n(rst_n),
        .is_standby(is_standby),
        .is_working(is_working),
        .self_clean_active(self_clean_active),
        .self_clean_done(self_clean_done),
        .clear_press_once(clear_press_once),
        .working_hour(working_hour),
        .working_min(working_min),
        .working_sec(working_sec),
        .count_state(count_state),
        .sec_tick(sec_tick),
        .saturated(saturated)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (sec_tick === 1'b1) ticks++;

    assign obs = {count_state, working_hour, working_min, working_sec, sec_tick, saturated};

    function automatic logic [21:0] pk(input int st, input int h, input int m, input int s,
                                       input int tk, input int sat);
        return {2'(st), 6'(h), 6'(m), 6'(s), 1'(tk), 1'(sat)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_cmp();
        exp_t e;
        e = sb.pop_front();
        n_assert++;
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
        end
    endtask

    task automatic go(input int n, input string tag, input logic [21:0] v);
        sb.push_back('{tag, v});
        step(n);
        pop_cmp();
    endtask

    task automatic cmp_int(input string tag, input int o, input int e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        #3;
        go(0, "reset", pk(0, 0, 0, 0, 0, 0));
        step(2);
        rst_n = 1'b1;
        // Asynchronous reset in the middle of a count
        is_working = 1'b1;
        go(1, "enter_count", pk(1, 0, 0, 0, 0, 0));
        go(37 * T, "at_37s", pk(1, 0, 0, 37, 1, 0));
        #2 rst_n = 1'b0;
        #1;
        go(0, "async_reset", pk(0, 0, 0, 0, 0, 0));
        is_working = 1'b0;
        step(1);
        rst_n = 1'b1;
        // Basic count and rollover chain
        t0 = ticks;
        is_working = 1'b1;
        go(1, "basic_enter", pk(1, 0, 0, 0, 0, 0));
        go(T - 1, "basic_pre", pk(1, 0, 0, 0, 0, 0));
        go(1, "basic_1s", pk(1, 0, 0, 1, 1, 0));
        go(1, "basic_tick_low", pk(1, 0, 0, 1, 0, 0));
        cmp_int("one_tick", ticks - t0, 1);
        go(59 * T - 1, "one_min", pk(1, 0, 1, 0, 1, 0));
        go((3599 - 60) * T, "at_0_59_59", pk(1, 0, 59, 59, 1, 0));
        go(T, "roll_1h", pk(1, 1, 0, 0, 1, 0));
        // Pause keeps the partial second
        step(1);
        is_working = 1'b0;
        go(1, "pause_stop", pk(0, 1, 0, 0, 0, 0));
        go(200, "pause_hold", pk(0, 1, 0, 0, 0, 0));
        is_working = 1'b1;
        go(2, "resume_pre", pk(1, 1, 0, 0, 0, 0));
        go(1, "resume_1s", pk(1, 1, 0, 1, 1, 0));
        go((7804 - 3601) * T, "at_2_10_04", pk(1, 2, 10, 4, 1, 0));
        clear_press_once = 1'b1;
        is_standby = 1'b1;
        go(1, "clear_in_count", pk(1, 2, 10, 4, 0, 0));
        clear_press_once = 1'b0;
        is_standby = 1'b0;
        // Self-clean arriving on a counted-second edge, abort, then completion
        step(T - 2);
        self_clean_active = 1'b1;
        go(1, "clean_edge_sec", pk(2, 2, 10, 5, 1, 0));
        is_working = 1'b0;
        go(10, "clean_hold", pk(2, 2, 10, 5, 0, 0));
        self_clean_active = 1'b0;
        go(1, "clean_abort", pk(0, 2, 10, 5, 0, 0));
        self_clean_active = 1'b1;
        go(1, "clean_again", pk(2, 2, 10, 5, 0, 0));
        self_clean_active = 1'b0;
        self_clean_done = 1'b1;
        go(1, "clean_done", pk(0, 0, 0, 0, 0, 0));
        self_clean_done = 1'b0;
        // Manual clear needs standby and STOP, and zeroes the prescaler
        is_working = 1'b1;
        go(1 + T, "pre_clear_1s", pk(1, 0, 0, 1, 1, 0));
        is_working = 1'b0;
        go(1, "pre_clear_stop", pk(0, 0, 0, 1, 0, 0));
        clear_press_once = 1'b1;
        go(1, "clear_no_standby", pk(0, 0, 0, 1, 0, 0));
        is_standby = 1'b1;
        go(1, "clear_standby", pk(0, 0, 0, 0, 0, 0));
        clear_press_once = 1'b0;
        is_standby = 1'b0;
        is_working = 1'b1;
        go(T, "post_clear_pre", pk(1, 0, 0, 0, 0, 0));
        go(1, "post_clear_1s", pk(1, 0, 0, 1, 1, 0));
        // Saturation
        go((10798 - 1) * T, "at_sat_minus1", pk(1, H, 59, 58, 1, 0));
        go(T, "saturate", pk(1, H, 59, 59, 1, 1));
        go(1, "sat_tick_low", pk(1, H, 59, 59, 0, 1));
        t0 = ticks;
        go(50, "sat_frozen", pk(1, H, 59, 59, 0, 1));
        cmp_int("sat_no_ticks", ticks - t0, 0);
        is_working = 1'b0;
        go(1, "sat_stop", pk(0, H, 59, 59, 0, 1));
        clear_press_once = 1'b1;
        is_standby = 1'b1;
        go(1, "sat_clear", pk(0, 0, 0, 0, 0, 0));
        clear_press_once = 1'b0;
        is_standby = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
